// File: rtl/demux_pkg.sv
// Shared constants and elaboration helpers for the 1-to-N stream demux.
// Holds the default geometry and a constant-foldable ceil(log2) for parameter checks.
package demux_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_N     = 4;
   localparam int DEFAULT_SEL_W = 2;

   function automatic int clog2(input int value);
      int result;
      result = 32'sd0;
      for (int i = 32'sd0; i < 32'sd31; i++) begin
         if ((32'sd1 << i) < value) begin
            result = i + 32'sd1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register: loads a beat, holds it under backpressure,
// and empties when the consumer takes it without a refill in the same cycle.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             drain,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   // Load wins over drain so a drained slot can be refilled on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= {WIDTH{1'b0}};
      end else if (load) begin
         valid <= 1'b1;
         data  <= load_data;
      end else if (drain) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

endmodule

// File: rtl/demux_1_to_n_stream.sv
// Registered 1-to-N valid/ready demux with broadcast. Each channel has its own
// holding slot so a stalled consumer only blocks beats addressed to it.
module demux_1_to_n_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N,
   parameter int SEL_W = DEFAULT_SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic               in_bcast,
   output logic [N-1:0]       out_valid,
   input  logic [N-1:0]       out_ready,
   output logic [N*WIDTH-1:0] out_data,
   output logic               sel_err
);

   if (SEL_W < clog2(N) || N < 2 || N > 16) begin : g_param_check
      $error("demux_1_to_n_stream: need 2 <= N <= 16 and SEL_W >= clog2(N)");
   end

   // One extra bit so N itself is representable when N == 2**SEL_W.
   localparam logic [SEL_W:0] N_EXT = N[SEL_W:0];

   logic         sel_ok_s;
   logic         accept_s;
   logic [N-1:0] free_s;
   logic [N-1:0] tgt_s;
   logic [N-1:0] load_s;

   assign sel_ok_s = ({1'b0, in_sel} < N_EXT);
   assign free_s   = ~out_valid | out_ready;

   // Illegal selects are always accepted so they can be dropped; otherwise every
   // targeted slot must be free, which makes broadcast all-or-nothing.
   assign in_ready = (in_bcast | sel_ok_s) ? (&(free_s | ~tgt_s)) : 1'b1;
   assign accept_s = in_valid & in_ready;
   assign load_s   = tgt_s & {N{accept_s}};

   for (genvar k = 0; k < N; k++) begin : g_slot
      localparam int KI = k;
      localparam logic [SEL_W-1:0] K_SEL = KI[SEL_W-1:0];

      assign tgt_s[k] = in_bcast | (sel_ok_s & (in_sel == K_SEL));

      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load_s[k]),
         .load_data (in_data),
         .drain     (out_ready[k]),
         .valid     (out_valid[k]),
         .data      (out_data[k*WIDTH +: WIDTH])
      );
   end

   // Flags a beat that was swallowed because its select addressed no channel.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err <= 1'b0;
      end else begin
         sel_err <= in_valid & ~in_bcast & ~sel_ok_s;
      end
   end

endmodule

// File: tb/tb_demux_1_to_n_stream.sv
// Self-checking bench: a 4-channel and a 3-channel demux share one input stream
// and are compared every cycle against a per-channel slot model.
module tb_demux_1_to_n_stream;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_bcast;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic [3:0] ory;

   logic [3:0]  ov4;
   logic [31:0] od4;
   logic        rdy4, err4;
   logic [2:0]  ov3;
   logic [23:0] od3;
   logic        rdy3, err3;

   always #5 clk = ~clk;

   demux_1_to_n_stream #(.WIDTH(8), .N(4), .SEL_W(2)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(ov4), .out_ready(ory), .out_data(od4), .sel_err(err4)
   );

   demux_1_to_n_stream #(.WIDTH(8), .N(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(ov3), .out_ready(ory[2:0]), .out_data(od3), .sel_err(err3)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: what each channel should be holding.
   bit         mv[2][4];
   logic [7:0] md[2][4];
   bit         merr[2];
   bit         after_rst;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int nch(input int i);
      return (i == 0) ? 4 : 3;
   endfunction

   function automatic bit exp_ready(input int i);
      bit all_free = 1'b1;
      int n = nch(i);
      for (int k = 0; k < n; k++)
         if (mv[i][k] && !ory[k]) all_free = 1'b0;
      if (in_bcast) return all_free;
      if (int'(in_sel) >= n) return 1'b1;
      return !mv[i][in_sel] || ory[in_sel];
   endfunction

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         int n = nch(i);
         bit acc = in_valid && exp_ready(i);
         if (rst) begin
            for (int k = 0; k < 4; k++) begin
               mv[i][k] = 1'b0;
               md[i][k] = 8'h00;
            end
            merr[i] = 1'b0;
         end else begin
            for (int k = 0; k < n; k++) begin
               if (acc && (in_bcast || int'(in_sel) == k)) begin
                  mv[i][k] = 1'b1;
                  md[i][k] = in_data;
               end else if (mv[i][k] && ory[k]) begin
                  mv[i][k] = 1'b0;
               end
            end
            merr[i] = in_valid && !in_bcast && int'(in_sel) >= n;
         end
      end
      after_rst = rst;
   endtask

   task automatic check_outputs();
      for (int i = 0; i < 2; i++) begin
         int n = nch(i);
         logic [3:0] expv = 4'h0;
         logic [3:0] gotv;
         gotv = (i == 0) ? ov4 : {1'b0, ov3};
         for (int k = 0; k < n; k++) expv[k] = mv[i][k];
         check_eq($sformatf("out_valid[n=%0d]", n), gotv, expv);
         check_eq($sformatf("sel_err[n=%0d]", n), (i == 0) ? err4 : err3, merr[i]);
         for (int k = 0; k < n; k++) begin
            if (mv[i][k] || after_rst)
               check_eq($sformatf("out_data[n=%0d][%0d]", n, k),
                        (i == 0) ? od4[k*8 +: 8] : od3[k*8 +: 8], md[i][k]);
         end
      end
   endtask

   task automatic step();
      #1;
      check_eq("in_ready[n=4]", rdy4, exp_ready(0));
      check_eq("in_ready[n=3]", rdy3, exp_ready(1));
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] s,
                        input bit b, input logic [3:0] r, input bit rs);
      in_valid = v;
      in_data  = d;
      in_sel   = s;
      in_bcast = b;
      ory      = r;
      rst      = rs;
   endtask

   initial begin
      drive(1'b1, 8'h3C, 2'd0, 1'b0, 4'hF, 1'b1);
      @(posedge clk);
      model_update();
      @(negedge clk);
      step();
      check_eq("reset_valid", ov4, 4'b0000);
      check_eq("reset_data", od4, 32'h0);

      // Unicast to channel 2, then dequeue.
      drive(1'b1, 8'hA5, 2'd2, 1'b0, 4'hF, 1'b0);
      step();
      check_eq("unicast_ch2", {ov4, od4[23:16]}, {4'b0100, 8'hA5});
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b0);
      step();

      // Backpressure on channel 1 must not block channel 3.
      drive(1'b1, 8'h11, 2'd1, 1'b0, 4'b1101, 1'b0);
      step();
      drive(1'b1, 8'h22, 2'd1, 1'b0, 4'b1101, 1'b0);
      step();
      drive(1'b1, 8'h33, 2'd3, 1'b0, 4'b1101, 1'b0);
      step();
      check_eq("stall_ch1_held", od4[15:8], 8'h11);
      drive(1'b1, 8'h22, 2'd1, 1'b0, 4'hF, 1'b0);
      step();
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b0);
      step();

      // Back-to-back beats on one channel.
      for (int j = 0; j < 8; j++) begin
         drive(1'b1, 8'(j), 2'd0, 1'b0, 4'hF, 1'b0);
         step();
      end

      // Broadcast waits for the occupied, stalled channel 3.
      drive(1'b1, 8'h77, 2'd3, 1'b0, 4'b0111, 1'b0);
      step();
      drive(1'b1, 8'h5C, 2'd1, 1'b1, 4'b0111, 1'b0);
      step();
      step();
      drive(1'b1, 8'h5C, 2'd1, 1'b1, 4'hF, 1'b0);
      step();
      check_eq("bcast_all", {ov4, od4}, {4'hF, 32'h5C5C5C5C});
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b0);
      step();

      // Select 3 is illegal only for the 3-channel instance.
      drive(1'b1, 8'hFF, 2'd3, 1'b0, 4'hF, 1'b0);
      step();
      check_eq("illegal_err", {err3, ov3}, {1'b1, 3'b000});
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 1'b0);
      step();

      // Reset while a beat is held discards it.
      drive(1'b1, 8'h09, 2'd0, 1'b0, 4'h0, 1'b0);
      step();
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'h0, 1'b1);
      step();

      for (int j = 0; j < 400; j++) begin
         drive(($urandom % 4) != 0, 8'($urandom), 2'($urandom), ($urandom % 8) == 0,
               (($urandom % 2) != 0) ? 4'hF : 4'($urandom), ($urandom % 60) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
